// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, oversampling ratio and bit-time helper.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int OVERSAMPLE = 8;
    localparam int CNT_W      = 19;

    // One bit time in clk cycles; a prescale of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] bit_time(input logic [15:0] ps);
        logic [15:0] ps_eff;
        ps_eff = (ps == 16'd0) ? 16'd1 : ps;
        return CNT_W'(ps_eff) * CNT_W'(OVERSAMPLE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
//  Module      : uart_sync
//  Description : N-flop synchronizer for asynchronous inputs, resets to 1.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    // Depths below two give no metastability protection, so clamp upward.
    localparam int c_n = (STAGES < 2) ? 2 : STAGES;

    logic [c_n-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[c_n-2:0], i_d};
        end
    end

    assign o_q = r_chain[c_n-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_axis.sv
// ============================================================================
//  Module      : uart_rx_axis
//  Description : 8N1 UART receiver with AXI-Stream output and error pulses.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overrun_error
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DATA_WIDTH - 1);

    logic                  w_rx_s;
    logic [CNT_W-1:0]      w_pb;
    logic [CNT_W-1:0]      w_half_m1;

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_pb;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_busy;
    logic                  r_ferr;
    logic                  r_oerr;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rx_s)
    );

    assign w_pb      = bit_time(prescale);
    assign w_half_m1 = (w_pb >> 1) - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_pb     <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_ferr   <= 1'b0;
            r_oerr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_oerr <= 1'b0;
            if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    // Bit time is frozen here so prescale changes cannot disturb a frame.
                    if (!w_rx_s) begin
                        r_pb    <= w_pb;
                        r_cnt   <= w_half_m1;
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_pb - 1'b1;
                        r_idx   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift[r_idx] <= w_rx_s;
                        r_cnt          <= r_pb - 1'b1;
                        if (r_idx == c_last_idx) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_rx_s) begin
                            r_tdata  <= r_shift;
                            r_tvalid <= 1'b1;
                            if (r_tvalid && !m_axis_tready) begin
                                r_oerr <= 1'b1;
                            end
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign busy          = r_busy;
    assign frame_error   = r_ferr;
    assign overrun_error = r_oerr;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_axis.sv
// ============================================================================
//  Module      : tb_uart_rx_axis
//  Description : Self-checking bench for uart_rx_axis driven by a UART line model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_axis;

    localparam int DW   = 8;
    localparam int SYNC = 2;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          rxd      = 1'b1;
    logic          tready   = 1'b1;
    logic [15:0]   prescale = 16'd1;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          busy;
    logic          ferr;
    logic          oerr;

    uart_rx_axis #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .prescale      (prescale),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .busy          (busy),
        .frame_error   (ferr),
        .overrun_error (oerr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_ferr   = 0;
    int   n_oerr   = 0;
    int   rise_cyc = -1;
    int   fall_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Observer: accepted bytes, error pulse counts, tvalid rising edge.
    always @(negedge clk) begin
        if (tvalid && tready) got_q.push_back(tdata);
        if (ferr) n_ferr++;
        if (oerr) n_oerr++;
        if (tvalid && !prev_valid) rise_cyc = cyc;
        prev_valid = tvalid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    // Cycles from the rxd start edge to the first cycle tvalid is visible.
    function automatic int exp_lat(input int pb);
        return SYNC + pb / 2 + (DW + 1) * pb + 1;
    endfunction

    // Drives the first nbits of a frame {stop, data, start}, LSB first.
    task automatic send_frame(input logic [7:0] d, input int pb, input logic stop_b, input int nbits);
        logic [9:0] bits;
        bits = {stop_b, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            rxd = bits[i];
            if (i == 0) fall_cyc = cyc;
            repeat (pb - 1) @(posedge clk);
        end
        if (nbits == 10 && !stop_b) begin
            @(posedge clk); #1;
            rxd = 1'b1;
        end
    endtask

    int         f0;
    int         o0;
    int         ps;
    logic [7:0] d;

    initial begin
        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_tdata",  32'(tdata),  32'd0);
        check("rst_ferr",   32'(ferr),   32'd0);
        check("rst_oerr",   32'(oerr),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Basic receive, prescale=1
        f0 = n_ferr; o0 = n_oerr; got_q.delete(); rise_cyc = -1;
        send_frame(8'h55, 8, 1'b1, 10);
        repeat (16) @(negedge clk);
        check("basic_count", 32'(got_q.size()), 32'd1);
        check("basic_data",  32'(got_at(0)), 32'h55);
        check("basic_lat",   32'(rise_cyc - fall_cyc), 32'(exp_lat(8)));
        check("basic_ferr",  32'(n_ferr - f0), 32'd0);
        check("basic_oerr",  32'(n_oerr - o0), 32'd0);
        check("basic_busy",  32'(busy), 32'd0);

        // Back-to-back with backpressure, prescale=2
        prescale = 16'd2;
        @(posedge clk); #1;
        tready = 1'b0;
        o0 = n_oerr; got_q.delete();
        send_frame(8'hA3, 16, 1'b1, 10);
        @(negedge clk);
        check("ovr_first_valid", 32'(tvalid), 32'd1);
        check("ovr_first_data",  32'(tdata),  32'hA3);
        send_frame(8'h0F, 16, 1'b1, 10);
        @(negedge clk);
        check("ovr_second_valid", 32'(tvalid), 32'd1);
        check("ovr_second_data",  32'(tdata),  32'h0F);
        check("ovr_pulses",       32'(n_oerr - o0), 32'd1);
        @(posedge clk); #1;
        tready = 1'b1;
        @(posedge clk); #1;
        tready = 1'b0;
        @(negedge clk);
        check("ovr_drop_valid", 32'(tvalid), 32'd0);
        check("ovr_accepted",   32'(got_q.size()), 32'd1);
        check("ovr_acc_data",   32'(got_at(0)), 32'h0F);
        @(posedge clk); #1;
        tready = 1'b1;

        // Framing error then a good frame
        prescale = 16'd1;
        f0 = n_ferr; got_q.delete();
        send_frame(8'hFF, 8, 1'b0, 10);
        repeat (24) @(negedge clk);
        check("fe_pulses", 32'(n_ferr - f0), 32'd1);
        check("fe_count",  32'(got_q.size()), 32'd0);
        check("fe_busy",   32'(busy), 32'd0);
        send_frame(8'h3C, 8, 1'b1, 10);
        repeat (16) @(negedge clk);
        check("fe_next_count", 32'(got_q.size()), 32'd1);
        check("fe_next_data",  32'(got_at(0)), 32'h3C);
        check("fe_next_ferr",  32'(n_ferr - f0), 32'd1);

        // Start glitch: rxd low for 3 cycles
        f0 = n_ferr; o0 = n_oerr; got_q.delete();
        @(posedge clk); #1;
        rxd = 1'b0;
        fall_cyc = cyc;
        repeat (3) @(posedge clk); #1;
        rxd = 1'b1;
        @(negedge clk);
        check("gl_busy_rise", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("gl_busy_hold", 32'(busy), 32'd1);
        @(negedge clk);
        check("gl_busy_fall", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check("gl_count", 32'(got_q.size()), 32'd0);
        check("gl_errs",  32'((n_ferr - f0) + (n_oerr - o0)), 32'd0);

        // Reset mid-frame with a pending byte
        @(posedge clk); #1;
        tready = 1'b0;
        f0 = n_ferr; o0 = n_oerr; got_q.delete();
        send_frame(8'h81, 8, 1'b1, 10);
        @(negedge clk);
        check("rmf_pending", 32'(tvalid), 32'd1);
        send_frame(8'h81, 8, 1'b1, 4);
        @(posedge clk); #1;
        rxd = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rmf_tvalid", 32'(tvalid), 32'd0);
        check("rmf_busy",   32'(busy),   32'd0);
        check("rmf_tdata",  32'(tdata),  32'd0);
        check("rmf_errs",   32'({ferr, oerr}), 32'd0);
        @(posedge clk); #1;
        tready = 1'b1;
        repeat (100) @(negedge clk);
        check("rmf_nothing", 32'(got_q.size()), 32'd0);
        send_frame(8'h81, 8, 1'b1, 10);
        repeat (16) @(negedge clk);
        check("rmf_next_count", 32'(got_q.size()), 32'd1);
        check("rmf_next_data",  32'(got_at(0)), 32'h81);
        check("rmf_next_errs",  32'((n_ferr - f0) + (n_oerr - o0)), 32'd0);

        // prescale=0 behaves as prescale=1
        prescale = 16'd0;
        got_q.delete(); rise_cyc = -1;
        send_frame(8'h5A, 8, 1'b1, 10);
        repeat (16) @(negedge clk);
        check("ps0_data", 32'(got_at(0)), 32'h5A);
        check("ps0_lat",  32'(rise_cyc - fall_cyc), 32'(exp_lat(8)));

        // prescale changed mid-frame
        prescale = 16'd2;
        got_q.delete();
        fork
            send_frame(8'hC6, 16, 1'b1, 10);
            begin
                repeat (50) @(posedge clk); #1;
                prescale = 16'd5;
            end
        join
        repeat (32) @(negedge clk);
        check("psmid_count", 32'(got_q.size()), 32'd1);
        check("psmid_data",  32'(got_at(0)), 32'hC6);

        // Randomized frames against the expected byte stream
        f0 = n_ferr; o0 = n_oerr; got_q.delete(); exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            ps = int'($urandom_range(1, 3));
            d  = 8'($urandom);
            prescale = 16'(ps);
            exp_q.push_back(d);
            send_frame(d, ps * 8, 1'b1, 10);
            repeat (int'($urandom_range(0, 2)) * 8) @(posedge clk);
        end
        repeat (64) @(negedge clk);
        check("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rnd_data%0d", i), 32'(got_at(i)), 32'(exp_q[i]));
        end
        check("rnd_errs", 32'((n_ferr - f0) + (n_oerr - o0)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
